// File: rtl/hack_pkg.sv
// Shared definitions for the Hack boot loader: state encoding and word/address widths.
package hack_pkg;

  localparam int unsigned HACK_WORD_W     = 16;
  localparam int unsigned HACK_ROM_ADDR_W = 15;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCsum,
    StFlush,
    StRun,
    StError
  } loader_state_e;

endpackage

// File: rtl/hack_rom_loader.sv
// Length-prefixed byte-stream loader for the Hack instruction ROM; holds the CPU in reset
// until the image is written. Optional XOR checksum byte: define HACK_LOADER_CHECKSUM_EN.
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W = HACK_ROM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_req,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   rom_we,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [HACK_WORD_W-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam loader_state_e AfterData = StCsum;
`else
  localparam loader_state_e AfterData = StFlush;
`endif

  loader_state_e              state_q;
  logic [7:0]                 hi_q;
  logic [ADDR_W:0]            len_q;
  logic [ADDR_W:0]            idx_q;
  logic [ADDR_W:0]            idx_inc;
  logic                       rom_we_q;
  logic [ADDR_W-1:0]          rom_addr_q;
  logic [HACK_WORD_W-1:0]     rom_wdata_q;
  logic                       cpu_reset_q;
  logic [31:0]                len_word;
  logic                       xfer;
  logic                       last_word;
  logic                       len_too_big;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]                 csum_q;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StDataHi, StDataLo: rx_ready = 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      StCsum:                               rx_ready = 1'b1;
`endif
      default:                              rx_ready = 1'b0;
    endcase
  end

  assign xfer        = rx_valid && rx_ready;
  assign len_word    = {16'h0000, hi_q, rx_data};
  // Index is one bit wider than the address so that a full 2^ADDR_W image is legal.
  assign len_too_big = len_word > (32'd1 << ADDR_W);
  assign idx_inc     = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word   = (idx_inc == len_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StLenHi;
      hi_q        <= 8'h00;
      len_q       <= '0;
      idx_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else if (load_req) begin
      state_q     <= StLenHi;
      idx_q       <= '0;
      rom_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      rom_we_q    <= 1'b0;
      // Lags the state by one edge so the last ROM write retires before the CPU starts.
      cpu_reset_q <= (state_q != StRun);
      case (state_q)
        StLenHi: begin
          if (xfer) begin
            hi_q    <= rx_data;
            state_q <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q <= len_word[ADDR_W:0];
            idx_q <= '0;
            if (len_too_big)             state_q <= StError;
            else if (len_word == 32'd0)  state_q <= AfterData;
            else                         state_q <= StDataHi;
          end
        end
        StDataHi: begin
          if (xfer) begin
            hi_q    <= rx_data;
            state_q <= StDataLo;
`ifdef HACK_LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ rx_data;
`endif
          end
        end
        StDataLo: begin
          if (xfer) begin
            rom_we_q    <= 1'b1;
            rom_addr_q  <= idx_q[ADDR_W-1:0];
            rom_wdata_q <= {hi_q, rx_data};
`ifdef HACK_LOADER_CHECKSUM_EN
            csum_q      <= csum_q ^ rx_data;
`endif
            if (last_word) begin
              state_q <= AfterData;
            end else begin
              idx_q   <= idx_inc;
              state_q <= StDataHi;
            end
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        StCsum: begin
          if (xfer) state_q <= (rx_data == csum_q) ? StFlush : StError;
        end
`endif
        StFlush: state_q <= StRun;
        default: ;
      endcase
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = (state_q == StRun);
  assign error     = (state_q == StError);

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot-time instruction loader that sits directly upstream of the Hack CPU. It receives a length-prefixed byte stream and writes 16-bit instruction words into the instruction ROM write port. It holds the CPU in reset (`cpu_reset`) until the image is complete and validated. It then releases the CPU, which starts fetching at pc = 0.

## Interface
- `ADDR_W`, default 15: ROM address width; capacity is 2^ADDR_W words (32768, matching the Hack ROM).
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, **active-low** reset.
- `load_req`  in  1: one-cycle pulse; aborts the current activity and restarts loading.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader can accept a byte; a byte transfers when `rx_valid && rx_ready`.
- `rom_we`  out  1: one-cycle ROM write strobe.
- `rom_addr`  out  ADDR_W: ROM write address.
- `rom_wdata`  out  16: ROM write data.
- `cpu_reset`  out  1: active-high reset to the CPU.
- `done`  out  1: image loaded; CPU running.
- `error`  out  1: load failed (bad length or bad checksum).

## Operation
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words sent as HI then LO byte, then an optional CSUM byte (see Configuration).
- FSM states and transitions:
  - `LEN_HI` → `LEN_LO`.
  - `LEN_LO` → `DATA_HI` if N > 0.
  - `LEN_LO` → `CSUM` (or `FLUSH`) if N = 0.
  - `LEN_LO` → `ERROR` if N > 2^ADDR_W.
  - `DATA_HI` → `DATA_LO`.
  - `DATA_LO` → `DATA_HI`, or `CSUM`/`FLUSH` after word N.
  - `CSUM` → `FLUSH` on match, `ERROR` on mismatch.
  - `FLUSH` → `RUN`.
- All data-path transitions occur only on an accepted byte.
- `rx_ready` is a combinational decode, 1 in `LEN_HI`, `LEN_LO`, `DATA_HI`, `DATA_LO` and `CSUM`, and 0 in `FLUSH`, `RUN` and `ERROR`.
- The word index counter runs 0..N-1 and is ADDR_W+1 bits wide so that N = 2^ADDR_W is legal.
- The HI byte is held in a register. On LO acceptance the outputs are registered as `rom_wdata = {hi, lo}`, `rom_addr = index`, and `rom_we = 1` for exactly one cycle.
- `cpu_reset` is 1 in every state except `RUN`. `done` is 1 only in `RUN`, and `error` is 1 only in `ERROR`.
- `load_req` in any state goes to `LEN_HI` on the next edge, clearing the index, the checksum and the `rom_we` pipeline. `cpu_reset` reasserts on that same edge.
- If `load_req` and a byte transfer occur in the same cycle, `load_req` wins and the byte is discarded.
- `ERROR` and `RUN` are exited only by `load_req` or by `reset`.

## Timing
- Reset values: state `LEN_HI`, `rx_ready` 1, `cpu_reset` 1, `rom_we` 0, `rom_addr` 0, `rom_wdata` 0, `done` 0, `error` 0.
- An asserted `reset` mid-load abandons the load immediately. Partially written ROM contents are not erased.
- ROM write latency: `rom_we` is high in the cycle after the LO byte is accepted.
- The `FLUSH` state guarantees that the final `rom_we` completes at least one edge before `cpu_reset` falls.
  - Without checksum: last LO byte accepted at edge k; `rom_we` high in k..k+1; `cpu_reset` low from edge k+2.
- Throughput: one byte per cycle when `rx_valid` is held high.

## Configuration
- `HACK_LOADER_CHECKSUM_EN` defined:
  - The CSUM byte follows the last data byte.
  - CSUM is the XOR of all data bytes only; length bytes are excluded.
  - A match goes to `FLUSH`; a mismatch goes to `ERROR` with the CPU kept in reset.
- `HACK_LOADER_CHECKSUM_EN` undefined:
  - The `CSUM` state and the accumulator are compiled out.
  - After the last data byte the FSM goes directly to `FLUSH`.

## Structure
- Shared package `hack_pkg` holds:
  - the loader state enum;
  - `HACK_WORD_W = 16`;
  - `HACK_ROM_ADDR_W = 15`, used as the `ADDR_W` default.
- The block is a single module with no sub-module. It contains the FSM, the HI-byte register, the index counter and the checksum accumulator.

## Test plan
- Checksum build; stream 00 03 30 39 EC 10 5B A0 0E:
  - writes 0x3039 to address 0, 0xEC10 to address 1 and 0x5BA0 to address 2;
  - `cpu_reset` falls 2 cycles after the CSUM byte is accepted; `done` = 1.
- Same stream with CSUM 0x0F → `error` = 1, `cpu_reset` stays 1, `rx_ready` = 0, and there are no further writes.
- Stream 00 00 (checksum build, followed by 00) → no `rom_we` pulses; `done` = 1.
- `ADDR_W` = 4; stream 00 11 (N = 17) → `ERROR` right after `LEN_LO`, with no writes.
- `load_req` pulsed after 3 data bytes, in the same cycle as the 4th byte:
  - that byte is dropped;
  - a new full stream loads cleanly starting at address 0.
- `rx_valid` toggled every other cycle → writes match the gap-free case, only spaced out in time. `reset` asserted mid-load → all outputs return to their reset values asynchronously.
